// File: rtl/reg_write_bank_if.sv
// Write-port bundle of the register bank: valid/ready write request,
// bulk-clear request, status outputs and the flat view of every entry.
interface reg_write_bank_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
);
    localparam int AW = $clog2(NREG);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  clr_req;
    logic                  busy;
    logic                  wr_commit;
    logic [NREG*WIDTH-1:0] regs_flat;

    // Requester side: issues writes and clear requests, observes the bank.
    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, wr_commit, regs_flat
    );

    // Bank side: owns the storage and the handshake response.
    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, busy, wr_commit, regs_flat
    );
endinterface

// File: rtl/reg_write_bank.sv
// Write side of the register file. Accepted writes sit in a one-entry
// staging register for a cycle and are committed on the next edge; a
// sequenced clear walks every entry to zero, one per cycle. Entry 0 is
// forced to zero at all times.
module reg_write_bank #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_write_bank_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             stg_valid_q, stg_valid_d;
    logic [AW-1:0]    stg_addr_q, stg_addr_d;
    logic [WIDTH-1:0] stg_data_q, stg_data_d;
    logic             commit_q, commit_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             accept;

    // A pending clear request blocks new writes so the clear wins a tie.
    assign bus.wr_ready  = (state_q == IDLE) && !bus.clr_req && rst_n;
    assign accept        = bus.wr_valid && bus.wr_ready;
    assign bus.busy      = busy_q;
    assign bus.wr_commit = commit_q;

    // Next-state: staging reload, commit of the staged write, clear sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        stg_valid_d = accept;
        stg_addr_d  = accept ? bus.wr_addr : stg_addr_q;
        stg_data_d  = accept ? bus.wr_data : stg_data_q;
        commit_d    = stg_valid_q;
        regs_d      = regs_q;

        // The staged write lands first, so a write staged just before a
        // clear request still commits before the clear starts.
        if (stg_valid_q && (stg_addr_q != '0)) begin
            regs_d[stg_addr_q] = stg_data_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        regs_d[0] = '0;
    end

    // State, staging and storage registers; reset zeroes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            stg_valid_q <= 1'b0;
            stg_addr_q  <= '0;
            stg_data_q  <= '0;
            commit_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stg_valid_q <= stg_valid_d;
            stg_addr_q  <= stg_addr_d;
            stg_data_q  <= stg_data_d;
            commit_q    <= commit_d;
            regs_q      <= regs_d;
        end
    end

    // Present every entry on the flat bus for the read-side mux.
    always_comb begin
        bus.regs_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            bus.regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end
endmodule

// File: tb/tb_reg_write_bank.sv
// Bench for reg_write_bank: directed vector table, hand-written clear and
// reset sequences, and random traffic against a queue-based reference model.
module tb_reg_write_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reg_write_bank_if #(.WIDTH(32), .NREG(32)) bus ();

    reg_write_bank #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, queue of accepted-but-uncommitted
    // writes, and clear progress.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] m_regs [32];
    wr_t         pend [$];
    bit          m_clearing;
    int          m_idx;
    bit          m_commit;

    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        bit          c;
        bit          exp_commit;
        bit          exp_busy;
        int          idx;
        logic [31:0] val;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1023:0] m_flat();
        logic [1023:0] f;
        for (int i = 0; i < 32; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic chk_flat(input string name);
        logic [1023:0] exp;
        exp = m_flat();
        checks++;
        if (bus.regs_flat !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, bus.regs_flat, exp, $time);
        end
    endtask

    function automatic logic [31:0] ent(input int i);
        return bus.regs_flat[i*32 +: 32];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        pend.delete();
        m_clearing = 0;
        m_idx = 0;
        m_commit = 0;
    endfunction

    function automatic void model_edge(input bit acc, input logic [4:0] a,
                                       input logic [31:0] d, input bit start_clr);
        wr_t w;
        m_commit = (pend.size() > 0);
        if (pend.size() > 0) begin
            w = pend.pop_front();
            if (w.a != 0) m_regs[w.a] = w.d;
        end
        if (m_clearing) begin
            m_regs[m_idx] = '0;
            m_idx++;
            if (m_idx == 32) m_clearing = 0;
        end else if (start_clr) begin
            m_clearing = 1;
            m_idx = 0;
        end
        if (acc) begin
            w.a = a;
            w.d = d;
            pend.push_back(w);
        end
    endfunction

    // One clock: drive inputs, check ready, advance, check all outputs.
    task automatic cycle(input bit v, input logic [4:0] a, input logic [31:0] d, input bit c);
        bit exp_rdy;
        bit was_clearing;
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.clr_req  = c;
        #1;
        was_clearing = m_clearing;
        exp_rdy = !was_clearing && !c;
        chk("wr_ready", 32'(bus.wr_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge(v && exp_rdy, a, d, c && !was_clearing);
        #1;
        chk("wr_commit", 32'(bus.wr_commit), 32'(m_commit));
        chk("busy", 32'(bus.busy), 32'(m_clearing));
        chk_flat("regs_flat");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        bit done;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 0, 32'h0};
        vecs[4] = '{1'b1, 5'd3, 32'h1,        1'b0, 1'b0, 1'b0, 3, 32'h0};
        vecs[5] = '{1'b1, 5'd3, 32'h2,        1'b0, 1'b1, 1'b0, 3, 32'h1};
        vecs[6] = '{1'b1, 5'd7, 32'h3,        1'b0, 1'b1, 1'b0, 3, 32'h2};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 7, 32'h3};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3, 32'h2};

        bus.wr_valid = 0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.wr_ready), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_commit", 32'(bus.wr_commit), 32'h0);
        chk_flat("rst_regs");
        rst_n = 1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].c);
            chk($sformatf("vec%0d_commit", i), 32'(bus.wr_commit), 32'(vecs[i].exp_commit));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_entry%0d", i, vecs[i].idx), ent(vecs[i].idx), vecs[i].val);
        end

        // Fill 1..31, then clear requested together with a write
        for (int i = 1; i < 32; i++) cycle(1, 5'(i), 32'(i), 0);
        cycle(0, 0, 0, 0);
        cycle(1, 5'd5, 32'hAAAA_AAAA, 1);
        busy_cnt = bus.busy ? 1 : 0;
        done = 0;
        for (int j = 1; j <= 40 && !done; j++) begin
            cycle(0, 0, 0, 0);
            if (bus.busy) busy_cnt++;
            else done = 1;
            if (j <= 32) chk($sformatf("clr_e%0d_zero", j - 1), ent(j - 1), 32'h0);
            if (j < 32) chk($sformatf("clr_e%0d_kept", j), ent(j), 32'(j));
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clr_ready_back", 32'(bus.wr_ready), 32'h1);

        // Write staged just before the clear commits first
        cycle(1, 5'd9, 32'h1234_5678, 0);
        cycle(0, 0, 0, 1);
        chk("pre_clr_e9", ent(9), 32'h1234_5678);
        for (int j = 1; j <= 32; j++) begin
            cycle(0, 0, 0, 0);
            if (j == 9) chk("e9_before_clear", ent(9), 32'h1234_5678);
            if (j == 10) chk("e9_cleared", ent(9), 32'h0);
        end

        // Reset in the middle of a clear
        cycle(1, 5'd20, 32'hCAFE_0020, 0);
        cycle(1, 5'd31, 32'hCAFE_0031, 0);
        cycle(0, 0, 0, 1);
        for (int j = 1; j <= 12; j++) cycle(0, 0, 0, 0);
        chk("midclr_e20", ent(20), 32'hCAFE_0020);
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst_ready", 32'(bus.wr_ready), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_commit", 32'(bus.wr_commit), 32'h0);
        chk_flat("midrst_regs");
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle(1, 5'd4, 32'h0BAD_F00D, 0);
        chk("post_rst_e4_edge1", ent(4), 32'h0);
        cycle(0, 0, 0, 0);
        chk("post_rst_e4_edge2", ent(4), 32'h0BAD_F00D);
        chk("post_rst_commit", 32'(bus.wr_commit), 32'h1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(bit'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  $urandom, bit'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
